// File: rtl/flash_sequencer.sv
// Shift-pulse generator that sweeps both flash patterns out, holds, sweeps back,
// and on disable walks both shifters back to centre before idling.
module flash_sequencer #(
   parameter int TICK_DIV   = 4,
   parameter int STEPS      = 3,
   parameter int HOLD_TICKS = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic flash1_shift_right,
   output logic flash1_shift_left,
   output logic flash2_shift_left,
   output logic flash2_shift_right,
   output logic busy
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PW = $clog2(STEPS + 1);
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [CW-1:0] CMAX = CW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PMAX = PW'(STEPS);
   localparam logic [HW-1:0] HMAX = HW'(HOLD_TICKS);

   typedef enum logic [2:0] {
      S_IDLE, S_OUT, S_HOLD, S_IN, S_RET
   } state_t;

   state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [PW-1:0] pos, pos_nx;
   logic [HW-1:0] hold, hold_nx;
   logic out_q, in_q, busy_q;
   logic out_nx, in_nx, busy_nx;
   logic tick, clr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         pos    <= '0;
         hold   <= '0;
         out_q  <= 1'b0;
         in_q   <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         pos    <= pos_nx;
         hold   <= hold_nx;
         out_q  <= out_nx;
         in_q   <= in_nx;
         busy_q <= busy_nx;
      end
   end

   assign tick = (state != S_IDLE) && (cnt == CMAX);

   always_comb begin
      state_nx = state;
      pos_nx   = pos;
      hold_nx  = hold;
      unique case (state)
         S_IDLE: begin
            pos_nx  = '0;
            hold_nx = '0;
            if (enable) state_nx = S_OUT;
         end
         S_OUT, S_HOLD, S_IN: begin
            // Disable wins over a same-edge tick
            if (!enable) begin
               state_nx = (pos == '0) ? S_IDLE : S_RET;
            end else if (tick) begin
               unique case (state)
                  S_OUT: begin
                     pos_nx = pos + 1'b1;
                     if (pos == PMAX - 1'b1) begin
                        state_nx = S_HOLD;
                        hold_nx  = '0;
                     end
                  end
                  S_HOLD: begin
                     hold_nx = hold + 1'b1;
                     if (hold == HMAX - 1'b1) state_nx = S_IN;
                  end
                  default: begin
                     pos_nx = pos - 1'b1;
                     if (pos == PW'(1)) state_nx = S_OUT;
                  end
               endcase
            end
         end
         S_RET: begin
            if (tick) begin
               pos_nx = pos - 1'b1;
               if (pos == PW'(1)) state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Prescaler restarts on entry to IDLE/RETURN only
   assign clr = (state == S_IDLE) || (state_nx == S_IDLE) ||
                (state_nx == S_RET && state != S_RET);
   assign cnt_nx = (clr || tick) ? '0 : cnt + 1'b1;

   always_comb begin
      out_nx  = tick && enable && (state == S_OUT);
      in_nx   = tick && ((state == S_IN && enable) || state == S_RET);
      busy_nx = (state_nx != S_IDLE) || in_nx;
   end

   assign flash1_shift_right = out_q;
   assign flash2_shift_left  = out_q;
   assign flash1_shift_left  = in_q;
   assign flash2_shift_right = in_q;
   assign busy               = busy_q;

endmodule

// File: tb/tb_flash_sequencer.sv
// Scoreboard bench: expected pulse cycles are queued by the stimulus and
// matched by a monitor; two shifter positions are tracked from the pulses.
module tb_flash_sequencer;

   logic clk = 1'b0;
   logic reset;
   logic enable;
   logic f1r, f1l, f2l, f2r, busy;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int f1v = 32;
   int f2v = 32;
   int exp_cyc[$];
   bit exp_dir[$];

   flash_sequencer #(.TICK_DIV(4), .STEPS(3), .HOLD_TICKS(2)) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .flash1_shift_right(f1r),
      .flash1_shift_left(f1l),
      .flash2_shift_left(f2l),
      .flash2_shift_right(f2r),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d",
                  name, act, exp, cyc);
      end
   endtask

   task automatic goto(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int c, input bit outward);
      exp_cyc.push_back(c);
      exp_dir.push_back(outward);
   endtask

   always @(negedge clk) begin
      int ec;
      bit ed;
      if (!reset) begin
         f1v = 32;
         f2v = 32;
      end else if (f1r || f1l || f2l || f2r) begin
         chk("pair", int'((f1r == f2l) && (f1l == f2r) && !(f1r && f1l)), 1);
         if (exp_cyc.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected pulse: out=%0b in=%0b at cycle %0d",
                     f1r, f1l, cyc);
         end else begin
            ec = exp_cyc.pop_front();
            ed = exp_dir.pop_front();
            chk("pulse_cycle", cyc, ec);
            chk("pulse_dir", int'(f1r), int'(ed));
         end
         if (f1r) begin
            f1v = f1v * 2;
            f2v = f2v / 2;
         end else if (f1l) begin
            f1v = f1v / 2;
            f2v = f2v * 2;
         end
      end
   end

   initial begin
      int e0, d, d2;
      reset  = 1'b0;
      enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_out", int'({f1r, f1l, f2l, f2r}), 0);
      reset = 1'b1;
      goto(cyc + 20);
      chk("idle_busy", int'(busy), 0);
      chk("idle_f1", f1v, 32);
      chk("idle_f2", f2v, 32);

      // first sweep, then disable in the second HOLD
      e0 = cyc + 1;
      enable = 1'b1;
      push(e0 + 4, 1); push(e0 + 8, 1); push(e0 + 12, 1);
      push(e0 + 24, 0); push(e0 + 28, 0); push(e0 + 32, 0);
      push(e0 + 36, 1); push(e0 + 40, 1); push(e0 + 44, 1);
      goto(e0);
      chk("en_busy", int'(busy), 1);
      goto(e0 + 13);
      chk("outer_f1", f1v, 256);
      chk("outer_f2", f2v, 4);
      goto(e0 + 33);
      chk("centre_f1", f1v, 32);
      chk("centre_f2", f2v, 32);
      goto(e0 + 45);
      enable = 1'b0;
      d = e0 + 46;
      push(d + 4, 0); push(d + 8, 0); push(d + 12, 0);
      goto(d + 12);
      chk("ret_busy", int'(busy), 1);
      goto(d + 13);
      chk("ret_idle", int'(busy), 0);
      chk("ret_f1", f1v, 32);
      chk("ret_f2", f2v, 32);

      // disable mid-OUT, re-enable during RETURN
      goto(cyc + 3);
      e0 = cyc + 1;
      enable = 1'b1;
      push(e0 + 4, 1);
      goto(e0 + 5);
      enable = 1'b0;
      d = e0 + 6;
      push(d + 4, 0);
      goto(d + 1);
      enable = 1'b1;
      push(d + 9, 1);
      goto(d + 5);
      chk("mid_f1", f1v, 32);
      chk("mid_busy", int'(busy), 1);
      goto(d + 10);
      enable = 1'b0;
      d2 = d + 11;
      push(d2 + 4, 0);
      goto(d2 + 5);
      chk("mid_idle", int'(busy), 0);
      chk("mid_f2", f2v, 32);

      // disable before first pulse
      goto(cyc + 3);
      e0 = cyc + 1;
      enable = 1'b1;
      goto(e0 + 1);
      chk("early_busy", int'(busy), 1);
      enable = 1'b0;
      goto(e0 + 2);
      chk("early_idle", int'(busy), 0);
      goto(e0 + 10);
      chk("early_still", int'(busy), 0);

      // asynchronous reset mid-OUT
      goto(cyc + 3);
      e0 = cyc + 1;
      enable = 1'b1;
      push(e0 + 4, 1);
      goto(e0 + 8);
      chk("pre_rst_pulse", int'(f1r), 1);
      #1 reset = 1'b0;
      #1;
      chk("async_out", int'({f1r, f1l, f2l, f2r}), 0);
      chk("async_busy", int'(busy), 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      e0 = cyc + 1;
      push(e0 + 4, 1); push(e0 + 8, 1); push(e0 + 12, 1);
      goto(e0 + 13);
      chk("fresh_f1", f1v, 256);
      chk("fresh_f2", f2v, 4);
      enable = 1'b0;
      d = e0 + 14;
      push(d + 4, 0); push(d + 8, 0); push(d + 12, 0);
      goto(d + 13);
      chk("fresh_idle", int'(busy), 0);
      chk("fresh_f1c", f1v, 32);
      chk("fresh_f2c", f2v, 32);
      goto(cyc + 5);
      chk("queue_empty", exp_cyc.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/flash_sequencer.md
# flash_sequencer

Pulse generator directly upstream of the two `shifter` instances in the bike-light datapath. While enabled, it sweeps both flash patterns outward from centre, holds, and sweeps them back, indefinitely. Each step is a single-cycle shift pulse on the shifters' `shift_left`/`shift_right` inputs. On disable it emits exactly enough inward pulses to return both shifters to centre (value 32), then idles.

## Interface
- `TICK_DIV`, 4: clock cycles per step tick; must be ≥ 2.
- `STEPS`, 3: outward pulses per sweep (32→256 on flash1, 32→4 on flash2); ≥ 1.
- `HOLD_TICKS`, 2: pulse-free ticks at the outer position; ≥ 1.

- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `enable`  in  1  level; 1 = run sweep, 0 = return to centre and stop.
- `flash1_shift_right`  out  1  one-cycle pulse, flash1 outward step.
- `flash1_shift_left`  out  1  one-cycle pulse, flash1 inward step.
- `flash2_shift_left`  out  1  one-cycle pulse, flash2 outward step.
- `flash2_shift_right`  out  1  one-cycle pulse, flash2 inward step.
- `busy`  out  1  1 whenever state ≠ IDLE.

## Operation
- **Registers:**
  - `cnt`: prescaler, `$clog2(TICK_DIV)` bits.
  - `pos`: steps away from centre, 0..`STEPS`.
  - `hold`: 0..`HOLD_TICKS`.
  - State: IDLE, OUT, HOLD, IN, RETURN.
- **Tick:** `cnt == TICK_DIV-1` in any non-IDLE state. `cnt` wraps to 0 on tick and is held at 0 in IDLE. It is also cleared on every state transition except OUT→HOLD, HOLD→IN, IN→OUT.
- **Outward pair:** `flash1_shift_right` + `flash2_shift_left`. **Inward pair:** `flash1_shift_left` + `flash2_shift_right`. Both bits of a pair are always asserted together; the outward and inward pairs are never asserted together.
- **IDLE:** outputs 0, `pos` = 0. `enable` = 1 → OUT.
- **OUT:** on each tick, pulse the outward pair and increment `pos`. When `pos` becomes `STEPS` → HOLD with `hold` = 0.
- **HOLD:** no pulses. On each tick, increment `hold`; on the `HOLD_TICKS`-th tick → IN.
- **IN:** on each tick, pulse the inward pair and decrement `pos`. When `pos` becomes 0 → OUT.
- **Disable:** `enable` = 0 sampled in OUT, HOLD or IN:
  - If `pos` = 0 → IDLE.
  - Otherwise → RETURN.
  - Disable has priority over a same-cycle tick: no pulse is emitted on that edge.
- **RETURN:** on each tick, pulse the inward pair and decrement `pos`. When `pos` = 0 → IDLE. `enable` is ignored in RETURN.
- **Position invariant:** `pos` always equals (outward pulses − inward pulses) issued since IDLE. `pos` never exceeds `STEPS` and never underflows.
- **Full-cycle period** with `enable` held high: (2·`STEPS` + `HOLD_TICKS`)·`TICK_DIV` clocks.

## Timing
- **Reset (`reset` low):** asynchronously forces IDLE, `cnt` = `pos` = `hold` = 0, and all five outputs 0. State is lost mid-sweep. The downstream shifters share this reset and return to 32, so no return pulses are owed.
- **Registered outputs:** all outputs are registered. A pulse is high for exactly one cycle, on the cycle after the tick edge. Pulses are separated by ≥ `TICK_DIV`−1 low cycles.
- **`enable` rise:** sampled at edge E0 (state → OUT, `busy` = 1 after E0). The first outward pulse is high during the cycle after edge E0+`TICK_DIV`.
- **`enable` fall:** sampled at edge D. `cnt` restarts, so the first return pulse occurs `TICK_DIV` cycles after D.
- **`busy` fall:** `busy` drops on the edge after the final return pulse is issued, i.e. on the same edge that clears that pulse.
- **HOLD→IN:** the transition emits no pulse. The first inward pulse comes one tick later.

## Test plan
With `TICK_DIV`=4, `STEPS`=3, `HOLD_TICKS`=2, each scenario also drives two `shifter` instances (flash1 with `is_flash_1`=1, flash2 with `is_flash_1`=0) from the outputs.

1. **Reset:** hold `reset` low, then release with `enable` = 0 → all outputs 0 and `busy` = 0 for 20 cycles; shifters stay at 32/32.
2. **First sweep:** assert `enable` at edge E0 →
   - Outward pulses 4, 8 and 12 cycles after E0, each one cycle wide.
   - flash1 goes 64, 128, 256; flash2 goes 16, 8, 4.
   - No pulses for the next 2 ticks.
   - Then inward pulses every 4 cycles; shifters back to 32/32.
   - Repeats with a 32-cycle period.
3. **Disable at outer position:** drop `enable` during HOLD (`pos` = 3) → exactly 3 inward pairs, shifters at 32/32, then `busy` = 0.
4. **Disable mid-OUT:** drop `enable` after one outward pulse → exactly 1 inward pair, then IDLE. Re-asserting `enable` during RETURN has no effect until IDLE.
5. **Disable before first pulse:** drop `enable` 2 cycles after E0 → no pulses at all; `busy` low on the next edge.
6. **Mid-operation reset:** assert `reset` low at `pos` = 2 in OUT → all outputs 0 immediately, with no clock edge needed. After release with `enable` = 1, a fresh sweep starts from `pos` = 0.
